// File: rtl/route_compute_unit.sv
// Route computation for one mesh-router input port. Captures the head-flit destination and
// issues a one-hot [c,n,e,s,w] request, which is held until granted and locked until the tail.
module route_compute_unit #(
    parameter int X_NODES = 4,
    parameter int Y_NODES = 4,
    parameter int X_LOC   = 0,
    parameter int Y_LOC   = 0,
    parameter int M       = 5,
    parameter int ROUTING = 0,
    parameter int WAIT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(X_NODES)-1:0] i_x_dest,
    input  logic [$clog2(Y_NODES)-1:0] i_y_dest,
    input  logic                       i_val,
    output logic                       o_ready,
    input  logic [0:M-1]               i_congested,
    input  logic                       i_grant,
    input  logic                       i_release,
    output logic [0:M-1]               o_output_req,
    output logic                       o_locked,
    output logic [WAIT_W-1:0]          o_wait_cycles
);
    localparam int XW = $clog2(X_NODES);
    localparam int YW = $clog2(Y_NODES);
    localparam logic [XW-1:0] X_HERE = X_LOC[XW-1:0];
    localparam logic [YW-1:0] Y_HERE = Y_LOC[YW-1:0];
    localparam bit ADAPTIVE = (ROUTING == 2);

    localparam logic [0:M-1] P_C = 5'b10000;
    localparam logic [0:M-1] P_N = 5'b01000;
    localparam logic [0:M-1] P_E = 5'b00100;
    localparam logic [0:M-1] P_S = 5'b00010;
    localparam logic [0:M-1] P_W = 5'b00001;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOCKED} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XW-1:0]       r_x_dest;
    logic [YW-1:0]       r_y_dest;
    logic [0:M-1]        r_req;
    logic [WAIT_W-1:0]   r_wait;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // West-first with both e and a y-port productive: leave e only when e is congested
    // and the y-port is clear; ties go to e.
    function automatic logic [0:M-1] route_fn(input logic [XW-1:0] xd,
                                              input logic [YW-1:0] yd,
                                              input logic [0:M-1]  cong);
        logic         xg, xl, yg, yl;
        logic [0:M-1] px, py, res;
        xg  = (xd > X_HERE);
        xl  = (xd < X_HERE);
        yg  = (yd > Y_HERE);
        yl  = (yd < Y_HERE);
        px  = xg ? P_E : (xl ? P_W : '0);
        py  = yg ? P_N : (yl ? P_S : '0);
        res = P_C;
        if (ROUTING == 1) begin
            if (py != '0)      res = py;
            else if (px != '0) res = px;
        end else if (ROUTING == 2) begin
            if (xl)                     res = P_W;
            else if (xg && (yg || yl))  res = (cong[2] && ((cong & py) == '0)) ? py : P_E;
            else if (xg)                res = P_E;
            else if (py != '0)          res = py;
        end else begin
            if (px != '0)      res = px;
            else if (py != '0) res = py;
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_val)     w_state_nxt = S_REQ;
            S_REQ:    if (i_grant)   w_state_nxt = i_release ? S_IDLE : S_LOCKED;
            S_LOCKED: if (i_release) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_dest <= '0;
            r_y_dest <= '0;
            r_req    <= '0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_val) begin
                        r_x_dest <= i_x_dest;
                        r_y_dest <= i_y_dest;
                        r_req    <= route_fn(i_x_dest, i_y_dest, i_congested);
                        r_wait   <= '0;
                    end
                end
                S_REQ: begin
                    // The grant cycle freezes the request so the locked port is the granted one.
                    if (i_grant) begin
                        if (i_release) r_req <= '0;
                    end else begin
                        r_wait <= sat_inc(r_wait);
                        if (ADAPTIVE) r_req <= route_fn(r_x_dest, r_y_dest, i_congested);
                    end
                end
                S_LOCKED: begin
                    if (i_release) r_req <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_ready       = (r_state == S_IDLE);
    assign o_locked      = (r_state == S_LOCKED);
    assign o_output_req  = r_req;
    assign o_wait_cycles = r_wait;

    a_loc_range: assert property (@(posedge clk)
        (X_LOC >= 0) && (X_LOC < X_NODES) && (Y_LOC >= 0) && (Y_LOC < Y_NODES) && (M == 5));
    a_req_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(o_output_req));
    a_req_active: assert property (@(posedge clk) disable iff (reset)
        (r_state != S_IDLE) |-> $onehot(o_output_req));
endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: three instances (XY, YX, west-first) at (1,1) in a 4x4 mesh
// share stimulus; a vector table covers routing, hand sequences cover multi-cycle behaviour.
module tb_route_compute_unit;
    logic       clk;
    logic       reset;
    logic [1:0] x_dest;
    logic [1:0] y_dest;
    logic       val;
    logic [0:4] cong;
    logic       grant;
    logic       release_i;

    logic       rdy_xy, rdy_yx, rdy_wf;
    logic       lck_xy, lck_yx, lck_wf;
    logic [0:4] req_xy, req_yx, req_wf;
    logic [7:0] wt_xy, wt_yx, wt_wf;

    int checks = 0;
    int errors = 0;

    route_compute_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .M(5), .ROUTING(0), .WAIT_W(8))
    u_xy (.clk(clk), .reset(reset), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .o_ready(rdy_xy), .i_congested(cong), .i_grant(grant), .i_release(release_i),
          .o_output_req(req_xy), .o_locked(lck_xy), .o_wait_cycles(wt_xy));

    route_compute_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .M(5), .ROUTING(1), .WAIT_W(8))
    u_yx (.clk(clk), .reset(reset), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .o_ready(rdy_yx), .i_congested(cong), .i_grant(grant), .i_release(release_i),
          .o_output_req(req_yx), .o_locked(lck_yx), .o_wait_cycles(wt_yx));

    route_compute_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .M(5), .ROUTING(2), .WAIT_W(8))
    u_wf (.clk(clk), .reset(reset), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .o_ready(rdy_wf), .i_congested(cong), .i_grant(grant), .i_release(release_i),
          .o_output_req(req_wf), .o_locked(lck_wf), .o_wait_cycles(wt_wf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] x;
        logic [1:0] y;
        logic [0:4] cong;
        logic [0:4] e_xy;
        logic [0:4] e_yx;
        logic [0:4] e_wf;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic head(input logic [1:0] x, input logic [1:0] y, input logic [0:4] c);
        x_dest = x; y_dest = y; cong = c; val = 1'b1;
        tick();
        val = 1'b0;
    endtask

    initial begin
        reset = 1'b1; val = 1'b0; x_dest = '0; y_dest = '0; cong = '0;
        grant = 1'b0; release_i = 1'b0;

        //           x     y     cong       XY         YX         WF
        tv[0] = '{2'd3, 2'd0, 5'b00000, 5'b00100, 5'b00010, 5'b00100};
        tv[1] = '{2'd1, 2'd1, 5'b00000, 5'b10000, 5'b10000, 5'b10000};
        tv[2] = '{2'd3, 2'd3, 5'b00100, 5'b00100, 5'b01000, 5'b01000};
        tv[3] = '{2'd0, 2'd3, 5'b01000, 5'b00001, 5'b01000, 5'b00001};
        tv[4] = '{2'd0, 2'd0, 5'b00000, 5'b00001, 5'b00010, 5'b00001};
        tv[5] = '{2'd1, 2'd3, 5'b00000, 5'b01000, 5'b01000, 5'b01000};
        tv[6] = '{2'd2, 2'd1, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
        tv[7] = '{2'd3, 2'd2, 5'b00110, 5'b00100, 5'b01000, 5'b01000};
        tv[8] = '{2'd3, 2'd0, 5'b00110, 5'b00100, 5'b00010, 5'b00100};

        repeat (2) tick();
        chk("rst_ready", 32'(rdy_wf), 32'd1);
        chk("rst_req",   32'(req_wf), 32'd0);
        chk("rst_lock",  32'(lck_wf), 32'd0);
        chk("rst_wait",  32'(wt_wf),  32'd0);
        reset = 1'b0;
        tick();

        // Table: head, check the request, then single-flit grant+release; heads back-to-back.
        for (int i = 0; i < 9; i++) begin
            head(tv[i].x, tv[i].y, tv[i].cong);
            chk($sformatf("v%0d_xy", i), 32'(req_xy), 32'(tv[i].e_xy));
            chk($sformatf("v%0d_yx", i), 32'(req_yx), 32'(tv[i].e_yx));
            chk($sformatf("v%0d_wf", i), 32'(req_wf), 32'(tv[i].e_wf));
            chk($sformatf("v%0d_rdy", i), 32'(rdy_wf), 32'd0);
            chk($sformatf("v%0d_wait", i), 32'(wt_xy), 32'd0);
            grant = 1'b1; release_i = 1'b1;
            tick();
            grant = 1'b0; release_i = 1'b0;
            chk($sformatf("v%0d_idle_rdy", i), 32'(rdy_yx), 32'd1);
            chk($sformatf("v%0d_idle_req", i), 32'(req_yx), 32'd0);
            chk($sformatf("v%0d_nolock", i), 32'(lck_yx), 32'd0);
        end

        // West-first re-selection while waiting, then lock on the granted port.
        head(2'd3, 2'd3, 5'b00100);
        chk("wf_first_n", 32'(req_wf), 32'b01000);
        cong = 5'b01000;
        tick();
        chk("wf_resel_e", 32'(req_wf), 32'b00100);
        chk("xy_stays_e", 32'(req_xy), 32'b00100);
        chk("yx_stays_n", 32'(req_yx), 32'b01000);
        chk("wf_wait1",   32'(wt_wf),  32'd1);
        grant = 1'b1; cong = 5'b00100;
        tick();
        grant = 1'b0; cong = 5'b01000;
        chk("wf_locked",     32'(lck_wf), 32'd1);
        chk("wf_lock_req",   32'(req_wf), 32'b00100);
        chk("wf_lock_wait",  32'(wt_wf),  32'd1);
        tick();
        chk("wf_lock_hold",  32'(req_wf), 32'b00100);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("wf_rel_ready",  32'(rdy_wf), 32'd1);
        chk("wf_rel_req",    32'(req_wf), 32'd0);
        chk("wf_rel_lock",   32'(lck_wf), 32'd0);

        // Grant while idle is ignored.
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("idle_grant_rdy",  32'(rdy_xy), 32'd1);
        chk("idle_grant_lock", 32'(lck_xy), 32'd0);

        // Wait-counter saturation; a head offered while busy must be ignored.
        head(2'd3, 2'd0, 5'b00000);
        chk("sat_start", 32'(wt_xy), 32'd0);
        for (int i = 1; i <= 300; i++) begin
            val = (i == 5); x_dest = 2'd0; y_dest = 2'd0;
            tick();
            if (i == 10)  chk("sat_w10",  32'(wt_xy), 32'd10);
            if (i == 255) chk("sat_w255", 32'(wt_xy), 32'd255);
        end
        val = 1'b0;
        chk("sat_w300",   32'(wt_xy),  32'd255);
        chk("sat_req",    32'(req_xy), 32'b00100);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("rel_in_req_rdy",  32'(rdy_xy), 32'd0);
        chk("rel_in_req_lock", 32'(lck_xy), 32'd0);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("sat_locked", 32'(lck_xy), 32'd1);
        repeat (3) tick();
        chk("sat_frozen", 32'(wt_xy), 32'd255);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        chk("sat_idle_rdy", 32'(rdy_xy), 32'd1);
        head(2'd1, 2'd1, 5'b00000);
        chk("next_head_wait", 32'(wt_xy),  32'd0);
        chk("next_head_req",  32'(req_xy), 32'b10000);
        grant = 1'b1; release_i = 1'b1;
        tick();
        grant = 1'b0; release_i = 1'b0;

        // Reset while locked abandons the route.
        head(2'd3, 2'd3, 5'b00000);
        repeat (2) tick();
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("pre_rst_lock", 32'(lck_wf), 32'd1);
        chk("pre_rst_wait", 32'(wt_wf),  32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_rdy",  32'(rdy_wf), 32'd1);
        chk("mid_rst_req",  32'(req_wf), 32'd0);
        chk("mid_rst_lock", 32'(lck_wf), 32'd0);
        chk("mid_rst_wait", 32'(wt_wf),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/route_compute_unit.md
Name: route_compute_unit

Overview:
- Per-input-port route computation stage for the mesh router.
- Registers the head-flit destination and computes a one-hot output-port request, ordered [c,n,e,s,w].
- Holds that request through switch allocation, then locks the route until the packet's tail is released.
- Supports XY, YX and west-first adaptive routing, with congestion-aware re-selection while waiting for a grant.
- Counts the cycles each request spends waiting for a grant.

Parameters:
- X_NODES, 4, number of node columns (≥2)
- Y_NODES, 4, number of node rows (≥2)
- X_LOC, 0, this router's column
- Y_LOC, 0, this router's row
- M, 5, number of output ports; fixed order [c,n,e,s,w]; only 5 is legal
- ROUTING, 0, routing algorithm: 0=XY, 1=YX, 2=WEST_FIRST
- WAIT_W, 8, width of the wait counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_x_dest  input  $clog2(X_NODES)  head-flit destination column
- i_y_dest  input  $clog2(Y_NODES)  head-flit destination row
- i_val  input  1  head flit valid
- o_ready  output  1  unit can accept a new head flit
- i_congested  input  M  per-output-port congestion flags, indexed like o_output_req
- i_grant  input  1  switch allocator granted the current request
- i_release  input  1  tail flit forwarded; free the route
- o_output_req  output  [0:M-1]  one-hot port request
- o_locked  output  1  route is allocated (granted, tail not yet released)
- o_wait_cycles  output  WAIT_W  saturating count of ungranted cycles for the current request

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset:
  - state=IDLE, o_ready=1
  - o_output_req='0, o_locked=0, o_wait_cycles=0
  - destination registers cleared
  - Reset asserted mid-packet (REQ or LOCKED) abandons the route in the same edge.
- Port encoding (index in [0:4]):
  - c=10000, n=01000, e=00100, s=00010, w=00001
  - Direction rules: x_dest>X_LOC → e; x_dest<X_LOC → w; y_dest>Y_LOC → n; y_dest<Y_LOC → s; both equal → c.
- States: IDLE, REQ, LOCKED.
- IDLE:
  - o_ready=1, o_output_req='0.
  - On i_val: capture the destination and compute the route.
  - Next cycle: state=REQ, o_output_req valid (latency 1 cycle), o_ready=0, o_wait_cycles=0.
- Route function:
  - XY: resolve x first, then y.
  - YX: resolve y first, then x.
  - WEST_FIRST:
    - x_dest<X_LOC → w (deterministic).
    - Otherwise the productive set is {e if x_dest>X_LOC} ∪ {n/s if y differs}.
    - One productive port → take it.
    - Two productive ports → choose the one whose i_congested bit is clear. If both are clear or both set, prefer e.
  - The c request occurs only when both coordinates match.
- REQ:
  - Hold o_output_req.
  - Each cycle without i_grant, o_wait_cycles increments, saturating at 2^WAIT_W-1.
  - In WEST_FIRST with two productive ports, re-evaluate the choice every ungranted cycle from the current i_congested. The new value appears on the next cycle.
  - XY and YX never change the request.
  - i_grant → LOCKED next cycle, request frozen. Re-selection in the grant cycle is suppressed, so the granted port is the one locked.
- LOCKED:
  - o_locked=1; o_output_req holds the granted port; o_wait_cycles frozen.
  - i_release → IDLE next cycle; o_ready=1 and o_output_req='0 in that cycle.
- Single-flit packets: i_grant and i_release together in REQ → IDLE directly. o_locked never asserts.
- Protocol rules:
  - i_release outside LOCKED/REQ-with-grant is ignored.
  - i_grant outside REQ is ignored.
  - i_val while o_ready=0 is ignored (the upstream buffer holds the flit).
- Debug checks: assertions flag X_LOC/Y_LOC out of range, and a one-hot violation on o_output_req.

Test Plan:
- 4x4 mesh, LOC=(1,1), XY. Head dest (3,0) → REQ next cycle with o_output_req=00100. Grant → o_locked=1. Release → o_ready=1 one cycle later.
- YX, same dest (3,0) → o_output_req=00010. Dest (1,1) under each of XY/YX/WEST_FIRST → 10000.
- WEST_FIRST, dest (3,3), i_congested=00100 → req 01000. Clear e-congestion and set n-congestion in REQ → req becomes 00100 next cycle. Dest (0,3) → 00001, unaffected by congestion.
- Hold i_grant low for 300 cycles with WAIT_W=8 → o_wait_cycles saturates at 255. Grant → value frozen through LOCKED, cleared on the next head.
- i_grant and i_release in the same REQ cycle → IDLE next cycle with o_locked never high. Back-to-back head accepted the cycle after.
- Assert reset while LOCKED → next cycle IDLE, o_output_req=0, o_locked=0, o_wait_cycles=0, o_ready=1.
